// File: rtl/dc_pkg.sv
// dc_pkg
// Shared definitions for the delay-compensation segment generator and its
// receive-side parser: framing characters, segment geometry, the payload
// layout and the transmit FSM state encoding.
package dc_pkg;

    localparam logic [7:0] K_START         = 8'h5C;
    localparam logic [7:0] K_STOP          = 8'h3C;
    localparam logic [7:0] DC_SEGMENT_ADDR = 8'hFF;

    localparam int SEGMENT_BYTES_COUNT  = 16;
    localparam int CHECKSUM_BYTES_COUNT = 2;

    // Big-endian on the wire: delay[31:24] is the first payload byte sent.
    typedef struct packed {
        logic [31:0] delay;
        logic [31:0] status;
        logic [31:0] reserved;
        logic [31:0] topoid;
    } dc_payload_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_STOP,
        ST_SUM_HI,
        ST_SUM_LO
    } dc_state_t;

    // Byte idx of the payload, idx 15 = most significant byte.
    function automatic logic [7:0] payload_byte(input dc_payload_t p, input logic [3:0] idx);
        logic [127:0] w_flat;
        w_flat = p;
        return w_flat[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dc_checksum_m.sv
// dc_checksum_m
// 16-bit subtractive checksum used by the DC segment. init reloads 0xFFFF,
// acc_en subtracts one byte (modulo 2^16). init wins over acc_en.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_init           reload the checksum with 0xFFFF
//   i_acc_en         subtract i_acc_byte from the checksum
//   i_acc_byte       byte to subtract
//   o_sum            current checksum value
module dc_checksum_m (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_init,
    input  logic        i_acc_en,
    input  logic [7:0]  i_acc_byte,
    output logic [15:0] o_sum
);

    logic [15:0] r_sum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum <= 16'hFFFF;
        end else if (i_init) begin
            r_sum <= 16'hFFFF;
        end else if (i_acc_en) begin
            r_sum <= r_sum - {8'h00, i_acc_byte};
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/dc_segment_tx_m.sv
// dc_segment_tx_m
// Master-side generator of the delay-compensation segment. Byte slots
// alternate between the distributed bus (phase 0) and segment data (phase 1).
// Frame on the data slots: K_START, address, 16 payload bytes, K_STOP,
// checksum high, checksum low. Idle data slots carry 0x00.
//
// Optional build macro: DC_TX_SEQNUM_EN -- when defined, the reserved payload
// word carries a 32-bit frame sequence counter incremented on every sent.
//
// Ports:
//   i_clk, i_rst_n    transmit byte clock, async active-low reset
//   i_valid           byte-slot enable; nothing advances while low
//   i_dbus            distributed-bus byte for phase-0 slots
//   i_delay           propagation delay (zero-extended to 32 bits)
//   i_status          link status (3 bits, zero-extended)
//   i_topoid          topology ID
//   i_force           request a segment now (any cycle)
//   o_tx_data/o_tx_isk  output byte and K flag
//   o_tx_valid        registered copy of i_valid
//   o_busy            segment in progress (start slot .. checksum low slot)
//   o_sent            one-cycle pulse with the last checksum byte
//
// state     | meaning
// ST_IDLE   | no frame; data slots emit 0x00, start when a request is pending
// ST_ADDR   | emit segment address
// ST_DATA   | emit payload byte r_idx (15 down to 0)
// ST_STOP   | emit stop comma
// ST_SUM_HI | emit checksum[15:8]
// ST_SUM_LO | emit checksum[7:0], pulse sent
module dc_segment_tx_m
    import dc_pkg::*;
#(
    parameter int DELAY_WIDTH = 32,
    parameter int PERIOD      = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    input  logic [7:0]             i_dbus,
    input  logic [DELAY_WIDTH-1:0] i_delay,
    input  logic [2:0]             i_status,
    input  logic [31:0]            i_topoid,
    input  logic                   i_force,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_isk,
    output logic                   o_tx_valid,
    output logic                   o_busy,
    output logic                   o_sent
);

    // A frame occupies 21 data slots; shorter periods would overrun it.
    localparam int P_EFF = (PERIOD == 0) ? 0 : ((PERIOD < 21) ? 21 : PERIOD);
    localparam logic [31:0] PERIOD_LAST = (P_EFF == 0) ? 32'd0 : 32'(P_EFF - 1);
    localparam bit PERIOD_EN = (P_EFF != 0);

    dc_state_t   r_state;
    logic [3:0]  r_idx;
    dc_payload_t r_payload;
    logic        r_phase;
    logic        r_pending;
    logic [31:0] r_period_cnt;

    logic [7:0]  r_tx_data;
    logic        r_tx_isk;
    logic        r_tx_valid;
    logic        r_busy;
    logic        r_sent;

    logic        w_data_slot;
    logic        w_start;
    logic        w_wrap;
    logic        w_last_slot;
    logic [7:0]  w_cur_byte;
    logic        w_cks_acc;
    logic [7:0]  w_cks_byte;
    logic [15:0] w_cks_sum;
    logic [31:0] w_reserved;
    dc_payload_t w_live_payload;

    assign w_data_slot = i_valid & r_phase;
    assign w_start     = w_data_slot & (r_state == ST_IDLE) & r_pending;
    assign w_wrap      = PERIOD_EN & w_data_slot & (r_period_cnt == PERIOD_LAST);
    assign w_last_slot = w_data_slot & (r_state == ST_SUM_LO);
    assign w_cur_byte  = payload_byte(r_payload, r_idx);
    assign w_cks_acc   = w_data_slot & ((r_state == ST_ADDR) | (r_state == ST_DATA));
    assign w_cks_byte  = (r_state == ST_ADDR) ? DC_SEGMENT_ADDR : w_cur_byte;

`ifdef DC_TX_SEQNUM_EN
    logic [31:0] r_seq;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seq <= '0;
        end else if (w_last_slot) begin
            r_seq <= r_seq + 32'd1;
        end
    end

    assign w_reserved = r_seq;
`else
    assign w_reserved = '0;
`endif

    always_comb begin
        w_live_payload          = '0;
        w_live_payload.delay    = 32'(i_delay);
        w_live_payload.status   = {29'b0, i_status};
        w_live_payload.reserved = w_reserved;
        w_live_payload.topoid   = i_topoid;
    end

    dc_checksum_m u_checksum (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_init     (w_start),
        .i_acc_en   (w_cks_acc),
        .i_acc_byte (w_cks_byte),
        .o_sum      (w_cks_sum)
    );

    // Free-running data-slot counter; keeps counting while a frame is busy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_period_cnt <= '0;
        end else if (w_data_slot && PERIOD_EN) begin
            if (w_wrap) begin
                r_period_cnt <= '0;
            end else begin
                r_period_cnt <= r_period_cnt + 32'd1;
            end
        end
    end

    // One-deep request flag; a new request on the start slot is kept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_start) | i_force | w_wrap;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_payload  <= '0;
            r_phase    <= 1'b0;
            r_tx_data  <= '0;
            r_tx_isk   <= 1'b0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_sent     <= 1'b0;
        end else if (!i_valid) begin
            r_tx_valid <= 1'b0;
            r_sent     <= 1'b0;
        end else begin
            r_tx_valid <= 1'b1;
            r_phase    <= ~r_phase;
            r_sent     <= 1'b0;
            if (!r_phase) begin
                r_tx_data <= i_dbus;
                r_tx_isk  <= 1'b0;
                r_busy    <= (r_state != ST_IDLE);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_pending) begin
                            r_tx_data <= K_START;
                            r_tx_isk  <= 1'b1;
                            r_busy    <= 1'b1;
                            r_payload <= w_live_payload;
                            r_state   <= ST_ADDR;
                        end else begin
                            r_tx_data <= 8'h00;
                            r_tx_isk  <= 1'b0;
                            r_busy    <= 1'b0;
                        end
                    end
                    ST_ADDR: begin
                        r_tx_data <= DC_SEGMENT_ADDR;
                        r_tx_isk  <= 1'b0;
                        r_busy    <= 1'b1;
                        r_idx     <= 4'(SEGMENT_BYTES_COUNT - 1);
                        r_state   <= ST_DATA;
                    end
                    ST_DATA: begin
                        r_tx_data <= w_cur_byte;
                        r_tx_isk  <= 1'b0;
                        r_busy    <= 1'b1;
                        r_idx     <= r_idx - 4'd1;
                        if (r_idx == 4'd0) begin
                            r_state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        r_tx_data <= K_STOP;
                        r_tx_isk  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SUM_HI;
                    end
                    ST_SUM_HI: begin
                        r_tx_data <= w_cks_sum[15:8];
                        r_tx_isk  <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SUM_LO;
                    end
                    ST_SUM_LO: begin
                        r_tx_data <= w_cks_sum[7:0];
                        r_tx_isk  <= 1'b0;
                        r_busy    <= 1'b1;
                        r_sent    <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                    default: begin
                        r_tx_data <= 8'h00;
                        r_tx_isk  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_isk   = r_tx_isk;
    assign o_tx_valid = r_tx_valid;
    assign o_busy     = r_busy;
    assign o_sent     = r_sent;

endmodule

// File: tb/tb_dc_segment_tx_m.sv
module tb_dc_segment_tx_m;

    localparam int PERIOD = 64;
    localparam int PEFF   = 64;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [7:0]  dbus;
    logic [31:0] delay;
    logic [2:0]  status;
    logic [31:0] topoid;
    logic        force_req;
    logic [7:0]  tx_data;
    logic        tx_isk;
    logic        tx_valid;
    logic        busy;
    logic        sent;

    dc_segment_tx_m #(.DELAY_WIDTH(32), .PERIOD(PERIOD)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .i_dbus     (dbus),
        .i_delay    (delay),
        .i_status   (status),
        .i_topoid   (topoid),
        .i_force    (force_req),
        .o_tx_data  (tx_data),
        .o_tx_isk   (tx_isk),
        .o_tx_valid (tx_valid),
        .o_busy     (busy),
        .o_sent     (sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: expected data-slot stream as a queue of {isk, byte}
    logic [8:0]  m_q[$];
    bit          m_phase;
    bit          m_pend;
    int          m_slots;
    logic [31:0] m_seq;
    logic [7:0]  cap_d[$];
    bit          cap_k[$];
    int          sent_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase = 0;
        m_pend  = 0;
        m_slots = 0;
        m_seq   = '0;
        cap_d.delete();
        cap_k.delete();
        sent_seen = 0;
    endtask

    task automatic push_frame();
        logic [127:0] p;
        logic [31:0]  res;
        int           s;
        int           c;
`ifdef DC_TX_SEQNUM_EN
        res = m_seq;
`else
        res = '0;
`endif
        p = {delay, {29'b0, status}, res, topoid};
        m_q.push_back({1'b1, 8'h5C});
        m_q.push_back({1'b0, 8'hFF});
        s = 255;
        for (int i = 15; i >= 0; i--) begin
            int b;
            b = int'(p[i*8 +: 8]);
            s += b;
            m_q.push_back({1'b0, 8'(b)});
        end
        m_q.push_back({1'b1, 8'h3C});
        c = (65535 - s) & 65535;
        m_q.push_back({1'b0, 8'(c / 256)});
        m_q.push_back({1'b0, 8'(c % 256)});
    endtask

    task automatic step(input bit v, input bit f);
        logic [7:0] e_data;
        bit         e_isk, e_busy, e_sent, wrap, is_data;
        logic [8:0] item;
        valid     = v;
        force_req = f;
        dbus      = 8'($urandom);
        e_data = 0; e_isk = 0; e_busy = 0; e_sent = 0; wrap = 0; is_data = 0;
        if (v) begin
            if (!m_phase) begin
                e_data = dbus;
                e_busy = (m_q.size() != 0);
            end else begin
                is_data = 1;
                if (m_q.size() == 0 && m_pend) begin
                    push_frame();
                    m_pend = 0;
                end
                if (m_q.size() != 0) begin
                    item   = m_q.pop_front();
                    e_data = item[7:0];
                    e_isk  = item[8];
                    e_busy = 1;
                    if (m_q.size() == 0) begin
                        e_sent = 1;
                        m_seq  = m_seq + 1;
                    end
                end
                m_slots++;
                wrap = (m_slots % PEFF) == 0;
            end
            m_phase = !m_phase;
        end
        if (f || wrap) m_pend = 1;
        @(posedge clk);
        #1;
        chk("tx_valid", 32'(tx_valid), 32'(v));
        chk("sent", 32'(sent), 32'(e_sent));
        if (sent) sent_seen++;
        if (v) begin
            chk("tx_data", 32'(tx_data), 32'(e_data));
            chk("tx_isk", 32'(tx_isk), 32'(e_isk));
            chk("busy", 32'(busy), 32'(e_busy));
        end
        if (is_data) begin
            cap_d.push_back(tx_data);
            cap_k.push_back(tx_isk);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_data"}, 32'(tx_data), 32'h0);
        chk({tag, "_isk"}, 32'(tx_isk), 32'h0);
        chk({tag, "_valid"}, 32'(tx_valid), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_sent"}, 32'(sent), 32'h0);
    endtask

    task automatic do_reset();
        valid = 0;
        force_req = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic check_frame_a(input string tag);
        logic [7:0] exp_a[21];
        exp_a = '{8'h5C, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h03,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h3C, 8'hFD, 8'hD9};
        if (cap_d.size() < 21) begin
            chk({tag, "_len"}, 32'(cap_d.size()), 32'd21);
        end else begin
            for (int i = 0; i < 21; i++) begin
                chk($sformatf("%s_byte%0d", tag, i), 32'(cap_d[i]), 32'(exp_a[i]));
                chk($sformatf("%s_isk%0d", tag, i), 32'(cap_k[i]), (i == 0 || i == 18) ? 32'd1 : 32'd0);
            end
        end
    endtask

    initial begin
        int p1, p2, nk;
        rst_n = 1; valid = 0; force_req = 0; dbus = 0;
        delay = 0; status = 0; topoid = 0;
        #2;
        do_reset();

        // Directed frame, delay changed mid-frame, periodic follow-up frame
        delay = 32'h10; status = 3'd3; topoid = 32'h12345678;
        step(1, 1);
        for (int i = 0; i < 179; i++) begin
            if (i == 10) delay = 32'hFFFF_FFFF;
            step(1, 0);
            if (i == 58) chk("sent_once", 32'(sent_seen), 32'd1);
        end
        check_frame_a("frameA");
        nk = 0;
        for (int i = 21; i < 64; i++) if (cap_d[i] != 8'h00 || cap_k[i]) nk++;
        chk("idle_zero", 32'(nk), 32'd0);
        chk("per_start", 32'(cap_d[64]), 32'h5C);
        for (int i = 66; i < 70; i++) chk("new_delay", 32'(cap_d[i]), 32'hFF);
`ifdef DC_TX_SEQNUM_EN
        chk("new_sum", {16'h0, cap_d[83], cap_d[84]}, 32'hF9EC);
`else
        chk("new_sum", {16'h0, cap_d[83], cap_d[84]}, 32'hF9ED);
`endif

        // Same frame with valid toggling
        do_reset();
        delay = 32'h10; status = 3'd3; topoid = 32'h12345678;
        step(1, 1);
        for (int i = 0; i < 100; i++) step((i % 2) == 1, 0);
        check_frame_a("toggle");

        // Force while busy, coincident with a period wrap
        do_reset();
        delay = $urandom; status = 3'($urandom); topoid = $urandom;
        while (m_slots < 45) step(1, 0);
        step(1, 1);
        while (m_slots < 100) step(1, m_phase && ((m_slots + 1) % PEFF == 0));
        nk = 0; p1 = -1; p2 = -1;
        for (int i = 40; i < 100; i++) begin
            if (cap_k[i] && cap_d[i] == 8'h5C) begin
                nk++;
                if (p1 < 0) p1 = i; else if (p2 < 0) p2 = i;
            end
        end
        chk("merge_frames", 32'(nk), 32'd2);
        chk("merge_gap", 32'(p2 - p1), 32'd21);

        // Reset during payload byte 7
        do_reset();
        delay = 32'hA5A5_0001; status = 3'd5; topoid = 32'hCAFE_F00D;
        step(1, 1);
        for (int i = 0; i < 100 && m_q.size() != 10; i++) step(1, 0);
        chk("at_byte7", 32'(m_q.size()), 32'd10);
        #3;
        rst_n = 0;
        #1;
        check_outputs_zero("async_rst");
        model_reset();
        valid = 0; force_req = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 180; i++) step(1, 0);
        nk = 0;
        for (int i = 0; i < 64; i++) if (cap_k[i]) nk++;
        chk("no_early_frame", 32'(nk), 32'd0);
        chk("post_rst_start", 32'(cap_d[64]), 32'h5C);
        for (int i = 74; i < 78; i++) chk("post_rst_resv", 32'(cap_d[i]), 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) delay = $urandom;
            if ($urandom_range(0, 19) == 0) status = 3'($urandom);
            if ($urandom_range(0, 19) == 0) topoid = $urandom;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
